trivium_encript: RTL and testbench
==================================

TRIVIUM_ENCRIPT -- requirements
Module: trivium_encript

Interface
REQ-001 SHALL have `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have `KEY`, input, 80 bits: Trivium key, sampled while `reset` is high.
REQ-004 SHALL have `IV`, input, 80 bits: Trivium IV, sampled while `reset` is high.
REQ-005 SHALL have `len`, input, 16 bits: number of keystream bits to produce, sampled while `reset` is high.
REQ-006 SHALL have `OUT`, output, 4096 bits: registered keystream buffer.
REQ-007 SHALL keep port order (`KEY`, `IV`, `len`, `clk`, `reset`, `OUT`) for positional instantiation.

Function
REQ-008 SHALL hold a 288-bit state s1..s288.
REQ-009 SHALL load the state on every reset edge as follows:
- s_i = KEY[i-1] for i = 1..80; s81..s93 = 0.
- s(93+i) = IV[i-1] for i = 1..80; s174..s177 = 0.
- s178..s285 = 0; s286, s287, s288 = 1.
REQ-010 SHALL compute each round as follows:
- t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3.
- t1 ^= (s91&s92)^s171; t2 ^= (s175&s176)^s264; t3 ^= (s286&s287)^s69.
REQ-011 SHALL shift the state each round as follows:
- s1..s93 <= {t3, s1..s92}.
- s94..s177 <= {t1, s94..s176}.
- s178..s288 <= {t2, s178..s287}.
REQ-012 SHALL run exactly 1152 warm-up rounds after reset release, one per clock; z is discarded during warm-up.
REQ-013 SHALL treat the first non-reset edge as warm-up round 1, and edge 1152+i as producing keystream bit z_i.
REQ-014 SHALL write z_i into OUT[i-1] at edge 1152+i; every other OUT bit holds its value.
REQ-015 SHALL clamp the effective length to min(len, 4096).
REQ-016 SHALL enter a terminal DONE state after the effective length is reached:
- state no longer advances;
- OUT holds until the next reset.
REQ-017 SHALL go from warm-up directly to DONE when len = 0, leaving OUT all-zero.
REQ-018 SHALL use a state machine with states LOAD (reset), INIT (warm-up counter 0..1151), GEN (bit counter 0..len-1) and DONE.
REQ-019 SHALL ignore changes on KEY, IV and len outside reset.

Reset
REQ-020 SHALL, while `reset` is high at an edge:
- clear OUT to all zeros;
- zero both counters;
- load the state per REQ-009;
- enter INIT on the first edge with `reset` low.
REQ-021 SHALL let a reset asserted mid-INIT or mid-GEN abort the operation at that edge with the same values as REQ-020.

Configuration
REQ-022 SHALL, with macro TRIVIUM_DONE_EN defined, add a 1-bit output `done` after `OUT`:
- 0 in reset, INIT and GEN;
- 1 from the edge on which DONE is entered until the next reset.
REQ-023 SHALL, without TRIVIUM_DONE_EN, omit the `done` port, with identical OUT behaviour.

Structure
REQ-024 SHALL place shared constants in package `trivium_pkg`:
- STATE_W = 288;
- INIT_ROUNDS = 1152;
- OUT_W = 4096;
- KEY_W = IV_W = 80;
- state-machine enum.
REQ-025 SHALL implement the combinational round (REQ-010/011) in sub-module `trivium_round`: inputs state[288]; outputs next_state[288] and z.

Verification
REQ-026 SHALL cover these directed scenarios:
- KEY=80'hFF000102030405060708, IV=0, len=4096: after 1152+4096 edges, OUT equals a bit-accurate software model; OUT unchanged 10000 cycles later.
- KEY=0, IV=0, len=4: OUT is 0 through edge 1152; OUT[0..3] match the model at edges 1153..1156; OUT[4095:4] stays 0.
- len=0: OUT stays all-zero for 2000 cycles; with TRIVIUM_DONE_EN, done rises at edge 1152.
- len=16'hFFFF: behaves as len=4096 and stops after edge 5248.
- Reset asserted at cycle 600 of warm-up, with a different KEY: OUT is cleared, and results match a fresh run with the new KEY.
- KEY/IV changed during GEN: OUT is unaffected and matches the original model.

Source files
------------

// File: rtl/trivium_pkg.sv
// trivium_pkg: shared widths, round counts and state-machine encoding for the Trivium keystream generator
package trivium_pkg;
  localparam int STATE_W = 288;
  localparam int INIT_ROUNDS = 1152;
  localparam int OUT_W = 4096;
  localparam int KEY_W = 80;
  localparam int IV_W = 80;
  typedef enum logic [1:0] {LOAD, INIT, GEN, DONE} fsm_t;
endpackage

// File: rtl/trivium_round.sv
// trivium_round: one combinational Trivium round; state[i-1] holds s_i
module trivium_round import trivium_pkg::*; (
  input logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] next_state,
  output logic z
);
  logic t1, t2, t3, n1, n2, n3;
  // linear taps give the output bit, nonlinear feedback closes each register
  always_comb begin
    t1 = state[65] ^ state[92];
    t2 = state[161] ^ state[176];
    t3 = state[242] ^ state[287];
    z = t1 ^ t2 ^ t3;
    n1 = t1 ^ (state[90] & state[91]) ^ state[170];
    n2 = t2 ^ (state[174] & state[175]) ^ state[263];
    n3 = t3 ^ (state[285] & state[286]) ^ state[68];
    next_state = {state[286:177], n2, state[175:93], n1, state[91:0], n3};
  end
endmodule

// File: rtl/trivium_encript.sv
// trivium_encript: Trivium keystream into a 4096-bit buffer; TRIVIUM_DONE_EN adds a done output
module trivium_encript import trivium_pkg::*; (
  input logic [KEY_W-1:0] KEY,
  input logic [IV_W-1:0] IV,
  input logic [15:0] len,
  input logic clk,
  input logic reset,
  output logic [OUT_W-1:0] OUT
`ifdef TRIVIUM_DONE_EN
  ,output logic done
`endif
);
  fsm_t fsm, fsm_nxt;
  logic [STATE_W-1:0] state, state_nxt;
  logic z, init_last, gen_last, warm, advance, wr;
  logic [10:0] init_cnt;
  logic [11:0] gen_cnt;
  logic [12:0] len_eff;
  trivium_round u_round (.state(state), .next_state(state_nxt), .z(z));
  assign init_last = init_cnt == 11'(INIT_ROUNDS - 1);
  assign gen_last = {1'b0, gen_cnt} == len_eff - 13'd1;
  // state register; LOAD also performs warm-up round 1 on the first free edge
  always_ff @(posedge clk) fsm <= reset ? LOAD : fsm_nxt;
  // next state: warm-up ends into GEN, or straight into DONE for a zero length
  always_comb fsm_nxt = warm ? (init_last ? (len_eff == '0 ? DONE : GEN) : INIT) : (fsm == GEN && gen_last) ? DONE : fsm;
  // per-state controls
  always_comb begin
    warm = fsm == LOAD || fsm == INIT;
    advance = fsm != DONE;
    wr = fsm == GEN;
  end
`ifdef TRIVIUM_DONE_EN
  assign done = fsm == DONE;
`endif
  // datapath: load on reset, then step the cipher and fill the buffer bit by bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= {3'b111, 112'b0, IV, 13'b0, KEY};
      OUT <= '0;
      init_cnt <= '0;
      gen_cnt <= '0;
      len_eff <= len > 16'(OUT_W) ? 13'(OUT_W) : len[12:0];
    end else begin
      if (advance) state <= state_nxt;
      if (warm) init_cnt <= init_last ? '0 : init_cnt + 11'd1;
      if (wr) begin
        OUT[gen_cnt] <= z;
        gen_cnt <= gen_cnt + 12'd1;
      end
    end
  end
endmodule

// File: tb/tb_trivium_encript.sv
// tb_trivium_encript: directed scenarios checked against a bit-serial Trivium software model
module tb_trivium_encript;
  logic clk = 0;
  logic reset = 1;
  logic [79:0] KEY = '0;
  logic [79:0] IV = '0;
  logic [15:0] len = '0;
  logic [4095:0] OUT;
  logic [4095:0] exp_v;
  int checks = 0;
  int failures = 0;
`ifdef TRIVIUM_DONE_EN
  logic done;
`endif
  trivium_encript dut (
    .KEY(KEY), .IV(IV), .len(len), .clk(clk), .reset(reset), .OUT(OUT)
`ifdef TRIVIUM_DONE_EN
    , .done(done)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [4095:0] model(input logic [79:0] k, input logic [79:0] v, input int n);
    bit s [1:288];
    bit t1, t2, t3;
    logic [4095:0] ks;
    ks = '0;
    for (int i = 1; i <= 288; i++) s[i] = 0;
    for (int i = 1; i <= 80; i++) begin
      s[i] = k[i-1];
      s[93+i] = v[i-1];
    end
    s[286] = 1; s[287] = 1; s[288] = 1;
    for (int r = 0; r < 1152 + n; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      if (r >= 1152) ks[r-1152] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int j = 288; j > 178; j--) s[j] = s[j-1];
      s[178] = t2;
      for (int j = 177; j > 94; j--) s[j] = s[j-1];
      s[94] = t1;
      for (int j = 93; j > 1; j--) s[j] = s[j-1];
      s[1] = t3;
    end
    return ks;
  endfunction
  task automatic check(input string tag, input logic [4095:0] got, input logic [4095:0] exp);
    int w;
    checks++;
    if (got !== exp) begin
      failures++;
      w = 0;
      for (int i = 4095; i >= 0; i--) if (got[i] !== exp[i]) w = i / 64;
      $display("FAIL %s: word %0d got %h exp %h", tag, w, got[w*64 +: 64], exp[w*64 +: 64]);
    end
  endtask
  task automatic start(input logic [79:0] k, input logic [79:0] v, input logic [15:0] l);
    @(negedge clk);
    reset = 1; KEY = k; IV = v; len = l;
    @(negedge clk);
    reset = 0;
  endtask
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    start(80'hFF000102030405060708, '0, 16'd4096);
    check("rst_out", OUT, '0);
`ifdef TRIVIUM_DONE_EN
    check("rst_done", 4096'(done), 4096'(0));
`endif
    exp_v = model(80'hFF000102030405060708, '0, 4096);
    edges(5247);
    check("full_5247", OUT, {1'b0, exp_v[4094:0]});
    edges(1);
    check("full_5248", OUT, exp_v);
    edges(10000);
    check("full_hold", OUT, exp_v);
    start(80'h0A0B0C0D0E0F10111213, 80'h1111, 16'd8);
    check("abort_clear", OUT, '0);
    edges(600);
    start(80'h99887766554433221100, 80'h2222, 16'd8);
    check("abort_rst", OUT, '0);
    edges(1160);
    check("abort_res", OUT, model(80'h99887766554433221100, 80'h2222, 8));
    start('0, '0, 16'd4);
    edges(1152);
    check("len4_1152", OUT, '0);
    for (int i = 1; i <= 4; i++) begin
      edges(1);
      check($sformatf("len4_bit%0d", i), OUT, model('0, '0, i));
    end
    edges(100);
    check("len4_hold", OUT, model('0, '0, 4));
    start(80'h5A5A5A5A5A5A5A5A5A5A, 80'h3C3C, 16'd0);
    edges(1151);
`ifdef TRIVIUM_DONE_EN
    check("len0_done_1151", 4096'(done), 4096'(0));
`endif
    edges(1);
`ifdef TRIVIUM_DONE_EN
    check("len0_done_1152", 4096'(done), 4096'(1));
`endif
    edges(848);
    check("len0_out", OUT, '0);
    start(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100123, 16'hFFFF);
    exp_v = model(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100123, 4096);
    edges(5247);
    check("ffff_5247", OUT, {1'b0, exp_v[4094:0]});
    edges(1);
    check("ffff_5248", OUT, exp_v);
`ifdef TRIVIUM_DONE_EN
    check("ffff_done", 4096'(done), 4096'(1));
`endif
    edges(50);
    check("ffff_stop", OUT, exp_v);
    start(80'hC0FFEE00DEADBEEF1234, 80'h0BADF00D, 16'd64);
    edges(1162);
    KEY = ~KEY; IV = ~IV; len = 16'd3;
    edges(54);
    check("chg_res", OUT, model(80'hC0FFEE00DEADBEEF1234, 80'h0BADF00D, 64));
    edges(20);
    check("chg_hold", OUT, model(80'hC0FFEE00DEADBEEF1234, 80'h0BADF00D, 64));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
